// File: rtl/ifetch_refill.sv
`default_nettype none
// ============================================================================
// ifetch_refill : PC owner, ICache lookup, byte-serial miss refill and fill.
// Option macro IFETCH_REFILL_BYPASS_EN: push the refilled word to the IQ directly.
// Rev 1.0
// ============================================================================
module ifetch_refill #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy_i,
   output logic [31:0] ic_addr_o,
   input  logic        ic_hit_i,
   input  logic [31:0] ic_inst_i,
   output logic        fill_en_o,
   output logic [31:0] fill_addr_o,
   output logic [31:0] fill_inst_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_byte_valid_i,
   input  logic [7:0]  mem_byte_i,
   input  logic        iq_full_i,
   output logic        iq_valid_o,
   output logic [31:0] iq_inst_o,
   output logic [31:0] iq_pc_o,
   input  logic        jump_en_i,
   input  logic [31:0] jump_pc_i
);

   typedef enum logic [1:0] {
      S_LOOKUP = 2'd0,
      S_REFILL = 2'd1,
      S_FILL   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] word_q, word_d;
   logic        mem_req_q, mem_req_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic        fill_en_q, fill_en_d;
   logic [31:0] fill_addr_q, fill_addr_d;
   logic [31:0] fill_inst_q, fill_inst_d;
   logic        iq_valid_q, iq_valid_d;
   logic [31:0] iq_inst_q, iq_inst_d;
   logic [31:0] iq_pc_q, iq_pc_d;

   // Strobes stay pending in their registers during a freeze and are masked
   // here, so each one reaches the consumer exactly once when rdy returns.
   assign ic_addr_o   = pc_q;
   assign fill_en_o   = fill_en_q & rdy_i;
   assign iq_valid_o  = iq_valid_q & rdy_i;
   assign fill_addr_o = fill_addr_q;
   assign fill_inst_o = fill_inst_q;
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign iq_inst_o   = iq_inst_q;
   assign iq_pc_o     = iq_pc_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      mem_req_d   = mem_req_q;
      mem_addr_d  = mem_addr_q;
      fill_en_d   = fill_en_q;
      fill_addr_d = fill_addr_q;
      fill_inst_d = fill_inst_q;
      iq_valid_d  = iq_valid_q;
      iq_inst_d   = iq_inst_q;
      iq_pc_d     = iq_pc_q;
      if (rdy_i) begin
         fill_en_d  = 1'b0;
         iq_valid_d = 1'b0;
         if (jump_en_i) begin
            pc_d      = {jump_pc_i[31:2], 2'b00};
            state_d   = S_LOOKUP;
            mem_req_d = 1'b0;
            cnt_d     = 2'd0;
         end else begin
            case (state_q)
               S_LOOKUP: begin
                  if (ic_hit_i) begin
                     if (!iq_full_i) begin
                        iq_valid_d = 1'b1;
                        iq_inst_d  = ic_inst_i;
                        iq_pc_d    = pc_q;
                        pc_d       = pc_q + 32'd4;
                     end
                  end else begin
                     state_d    = S_REFILL;
                     mem_req_d  = 1'b1;
                     cnt_d      = 2'd0;
                     mem_addr_d = {pc_q[31:2], 2'b00};
                  end
               end
               S_REFILL: begin
                  if (mem_byte_valid_i) begin
                     if (cnt_q == 2'd3) begin
                        state_d     = S_FILL;
                        mem_req_d   = 1'b0;
                        cnt_d       = 2'd0;
                        fill_en_d   = 1'b1;
                        fill_addr_d = pc_q;
                        fill_inst_d = {mem_byte_i, word_q};
`ifdef IFETCH_REFILL_BYPASS_EN
                        if (!iq_full_i) begin
                           iq_valid_d = 1'b1;
                           iq_inst_d  = {mem_byte_i, word_q};
                           iq_pc_d    = pc_q;
                           pc_d       = pc_q + 32'd4;
                        end
`endif
                     end else begin
                        case (cnt_q)
                           2'd0:    word_d[7:0]   = mem_byte_i;
                           2'd1:    word_d[15:8]  = mem_byte_i;
                           default: word_d[23:16] = mem_byte_i;
                        endcase
                        cnt_d = cnt_q + 2'd1;
                     end
                  end
               end
               S_FILL:  state_d = S_LOOKUP;
               default: state_d = S_LOOKUP;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_LOOKUP;
         pc_q        <= RESET_PC;
         cnt_q       <= 2'd0;
         word_q      <= 24'd0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= 32'd0;
         fill_en_q   <= 1'b0;
         fill_addr_q <= 32'd0;
         fill_inst_q <= 32'd0;
         iq_valid_q  <= 1'b0;
         iq_inst_q   <= 32'd0;
         iq_pc_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         mem_req_q   <= mem_req_d;
         mem_addr_q  <= mem_addr_d;
         fill_en_q   <= fill_en_d;
         fill_addr_q <= fill_addr_d;
         fill_inst_q <= fill_inst_d;
         iq_valid_q  <= iq_valid_d;
         iq_inst_q   <= iq_inst_d;
         iq_pc_q     <= iq_pc_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_refill.sv
`default_nettype none
// ============================================================================
// tb_ifetch_refill : directed bench with a small tag-checked ICache model.
// Rev 1.0
// ============================================================================
module tb_ifetch_refill;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        ic_hit, fill_en, mem_req, iq_valid;
   logic        mem_bv = 1'b0;
   logic        iq_full = 1'b0;
   logic        jump_en = 1'b0;
   logic [31:0] ic_addr, ic_inst, fill_addr, fill_inst, mem_addr, iq_inst, iq_pc;
   logic [31:0] jump_pc = 32'd0;
   logic [7:0]  mem_byte = 8'd0;
   logic        preload = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int n_fill   = 0;
   int n_push200 = 0;
   int fill_base;
   logic ok;

   bit        c_valid [16];
   bit [31:0] c_tag   [16];
   bit [31:0] c_data  [16];

   always #5 clk = ~clk;

   ifetch_refill #(.RESET_PC(32'h100)) dut (
      .clk(clk), .rst(rst), .rdy_i(rdy),
      .ic_addr_o(ic_addr), .ic_hit_i(ic_hit), .ic_inst_i(ic_inst),
      .fill_en_o(fill_en), .fill_addr_o(fill_addr), .fill_inst_o(fill_inst),
      .mem_req_o(mem_req), .mem_addr_o(mem_addr),
      .mem_byte_valid_i(mem_bv), .mem_byte_i(mem_byte),
      .iq_full_i(iq_full), .iq_valid_o(iq_valid), .iq_inst_o(iq_inst), .iq_pc_o(iq_pc),
      .jump_en_i(jump_en), .jump_pc_i(jump_pc)
   );

   // Direct-mapped by addr[5:2] with a full-address tag; writes land at the clock edge.
   assign ic_hit  = c_valid[ic_addr[5:2]] && (c_tag[ic_addr[5:2]] == ic_addr);
   assign ic_inst = c_data[ic_addr[5:2]];

   always @(posedge clk) begin
      if (fill_en) begin
         c_valid[fill_addr[5:2]] <= 1'b1;
         c_tag[fill_addr[5:2]]   <= fill_addr;
         c_data[fill_addr[5:2]]  <= fill_inst;
         n_fill <= n_fill + 1;
      end
      if (iq_valid && iq_pc == 32'h200) n_push200 <= n_push200 + 1;
      if (preload) begin
         for (int i = 0; i < 4; i++) begin
            c_valid[i] <= 1'b1;
            c_tag[i]   <= 32'(i * 4);
            c_data[i]  <= 32'h1000_0000 + 32'(i * 4);
         end
         c_valid[15] <= 1'b1;
         c_tag[15]   <= 32'hFFFF_FFFC;
         c_data[15]  <= 32'hCAFE_F00D;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_req, fill_en, iq_valid} !== 3'b000) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 000", {mem_req, fill_en, iq_valid});
      end
      n_checks++;
      if (ic_addr !== 32'h100) begin
         n_fail++; $display("FAIL reset_pc: got %h expected 00000100", ic_addr);
      end
      n_checks++;
      if ({iq_inst, iq_pc, fill_addr, fill_inst, mem_addr} !== 160'd0) begin
         n_fail++; $display("FAIL reset_regs: got %h %h %h %h %h expected all 0",
                            iq_inst, iq_pc, fill_addr, fill_inst, mem_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100) begin
         n_fail++; $display("FAIL cold_miss: got req=%b addr=%h expected req=1 addr=00000100", mem_req, mem_addr);
      end
   endtask

   task automatic test_miss_refill();
      logic [7:0] bs [4];
      bs = '{8'h13, 8'h00, 8'h50, 8'h00};
      for (int i = 0; i < 4; i++) begin
         mem_bv = 1'b1; mem_byte = bs[i];
         @(negedge clk);
      end
      mem_bv = 1'b0;
      n_checks++;
      if (fill_en !== 1'b1 || fill_addr !== 32'h100 || fill_inst !== 32'h0050_0013 || mem_req !== 1'b0) begin
         n_fail++; $display("FAIL fill_word: got en=%b addr=%h inst=%h req=%b expected 1 00000100 00500013 0",
                            fill_en, fill_addr, fill_inst, mem_req);
      end
`ifdef IFETCH_REFILL_BYPASS_EN
      n_checks++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'h100 || iq_inst !== 32'h0050_0013) begin
         n_fail++; $display("FAIL bypass_push: got v=%b pc=%h inst=%h expected 1 00000100 00500013", iq_valid, iq_pc, iq_inst);
      end
      @(negedge clk);
      n_checks++;
      if (fill_en !== 1'b0) begin
         n_fail++; $display("FAIL fill_one_cycle: got %b expected 0", fill_en);
      end
`else
      n_checks++;
      if (iq_valid !== 1'b0) begin
         n_fail++; $display("FAIL early_push_fill: got %b expected 0", iq_valid);
      end
      @(negedge clk);
      n_checks++;
      if (fill_en !== 1'b0 || iq_valid !== 1'b0) begin
         n_fail++; $display("FAIL fill_one_cycle: got en=%b v=%b expected 0 0", fill_en, iq_valid);
      end
      @(negedge clk);
      n_checks++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'h100 || iq_inst !== 32'h0050_0013) begin
         n_fail++; $display("FAIL relookup_push: got v=%b pc=%h inst=%h expected 1 00000100 00500013", iq_valid, iq_pc, iq_inst);
      end
`endif
   endtask

   task automatic test_reset_abort();
      ok = 1'b0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok || mem_addr !== 32'h104) begin
         n_fail++; $display("FAIL next_miss: got req_seen=%b addr=%h expected 1 00000104", ok, mem_addr);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b0 || ic_addr !== 32'h100) begin
         n_fail++; $display("FAIL reset_abort: got req=%b pc=%h expected 0 00000100", mem_req, ic_addr);
      end
      preload = 1'b1;
      @(negedge clk);
      preload = 1'b0;
   endtask

   task automatic test_hits();
      rst = 1'b0; jump_en = 1'b1; jump_pc = 32'h0;
      @(negedge clk);
      jump_en = 1'b0;
      n_checks++;
      if (ic_addr !== 32'h0 || iq_valid !== 1'b0) begin
         n_fail++; $display("FAIL jump_to_0: got pc=%h v=%b expected 00000000 0", ic_addr, iq_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (iq_valid !== 1'b1 || iq_pc !== 32'(i * 4) || iq_inst !== 32'h1000_0000 + 32'(i * 4)) begin
            n_fail++; $display("FAIL hit_stream[%0d]: got v=%b pc=%h inst=%h expected 1 %h %h",
                               i, iq_valid, iq_pc, iq_inst, 32'(i * 4), 32'h1000_0000 + 32'(i * 4));
         end
      end
      @(negedge clk);
      n_checks++;
      if (iq_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         n_fail++; $display("FAIL miss_after_hits: got v=%b req=%b addr=%h expected 0 1 00000010", iq_valid, mem_req, mem_addr);
      end
   endtask

   task automatic test_iq_full();
      jump_en = 1'b1; jump_pc = 32'h0;
      @(negedge clk);
      jump_en = 1'b0;
      n_checks++;
      if (mem_req !== 1'b0) begin
         n_fail++; $display("FAIL jump_drops_req: got %b expected 0", mem_req);
      end
      @(negedge clk);
      n_checks++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'h0) begin
         n_fail++; $display("FAIL full_first_push: got v=%b pc=%h expected 1 00000000", iq_valid, iq_pc);
      end
      iq_full = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (iq_valid !== 1'b0 || ic_addr !== 32'h4) begin
            n_fail++; $display("FAIL full_stall: got v=%b pc=%h expected 0 00000004", iq_valid, ic_addr);
         end
      end
      iq_full = 1'b0;
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (iq_valid !== 1'b1 || iq_pc !== 32'(i * 4)) begin
            n_fail++; $display("FAIL full_resume[%0d]: got v=%b pc=%h expected 1 %h", i, iq_valid, iq_pc, 32'(i * 4));
         end
      end
   endtask

   task automatic test_jump_refill();
      ok = 1'b0;
      for (int i = 0; i < 5 && !ok; i++) begin
         @(negedge clk);
         if (mem_req === 1'b1) ok = 1'b1;
      end
      n_checks++;
      if (!ok || mem_addr !== 32'h10) begin
         n_fail++; $display("FAIL refill_start: got req_seen=%b addr=%h expected 1 00000010", ok, mem_addr);
      end
      fill_base = n_fill;
      mem_bv = 1'b1; mem_byte = 8'h11;
      @(negedge clk);
      mem_byte = 8'h22;
      @(negedge clk);
      jump_en = 1'b1; jump_pc = 32'h203; mem_byte = 8'h33;
      @(negedge clk);
      jump_en = 1'b0; mem_byte = 8'h44;
      n_checks++;
      if (mem_req !== 1'b0 || ic_addr !== 32'h200 || fill_en !== 1'b0) begin
         n_fail++; $display("FAIL jump_mid_refill: got req=%b pc=%h fill=%b expected 0 00000200 0", mem_req, ic_addr, fill_en);
      end
      @(negedge clk);
      mem_bv = 1'b0;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         n_fail++; $display("FAIL jump_target_miss: got req=%b addr=%h expected 1 00000200", mem_req, mem_addr);
      end
   endtask

   task automatic test_rdy_stall();
      mem_bv = 1'b1; mem_byte = 8'h93;
      @(negedge clk);
      mem_byte = 8'h00;
      @(negedge clk);
      rdy = 1'b0; mem_byte = 8'hEE;
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if ({mem_req, fill_en, iq_valid} !== 3'b100 || mem_addr !== 32'h200) begin
            n_fail++; $display("FAIL rdy_refill_hold: got req/fill/v=%b addr=%h expected 100 00000200",
                               {mem_req, fill_en, iq_valid}, mem_addr);
         end
      end
      rdy = 1'b1; mem_byte = 8'h10;
      @(negedge clk);
      mem_byte = 8'h00;
      @(negedge clk);
      mem_bv = 1'b0;
      n_checks++;
      if (fill_en !== 1'b1 || fill_addr !== 32'h200 || fill_inst !== 32'h0010_0093) begin
         n_fail++; $display("FAIL stall_fill_word: got en=%b addr=%h inst=%h expected 1 00000200 00100093",
                            fill_en, fill_addr, fill_inst);
      end
`ifdef IFETCH_REFILL_BYPASS_EN
      n_checks++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'h200) begin
         n_fail++; $display("FAIL stall_bypass_push: got v=%b pc=%h expected 1 00000200", iq_valid, iq_pc);
      end
`endif
      rdy = 1'b0;
      repeat (5) begin
         @(negedge clk);
         n_checks++;
         if (fill_en !== 1'b0 || iq_valid !== 1'b0) begin
            n_fail++; $display("FAIL rdy_fill_hold: got fill=%b v=%b expected 0 0", fill_en, iq_valid);
         end
      end
      rdy = 1'b1;
      #1;
      n_checks++;
      if (fill_en !== 1'b1) begin
         n_fail++; $display("FAIL fill_reassert: got %b expected 1", fill_en);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (n_fill - fill_base !== 1 || n_push200 !== 1) begin
         n_fail++; $display("FAIL single_fill_push: got fills=%0d pushes=%0d expected 1 1", n_fill - fill_base, n_push200);
      end
   endtask

   task automatic test_wrap();
      jump_en = 1'b1; jump_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      jump_en = 1'b0;
      n_checks++;
      if (ic_addr !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL jump_align: got %h expected fffffffc", ic_addr);
      end
      @(negedge clk);
      n_checks++;
      if (iq_valid !== 1'b1 || iq_pc !== 32'hFFFF_FFFC || iq_inst !== 32'hCAFE_F00D || ic_addr !== 32'h0) begin
         n_fail++; $display("FAIL pc_wrap: got v=%b pc=%h inst=%h next=%h expected 1 fffffffc cafef00d 00000000",
                            iq_valid, iq_pc, iq_inst, ic_addr);
      end
   endtask

   initial begin
      test_reset();
      test_miss_refill();
      test_reset_abort();
      test_hits();
      test_iq_full();
      test_jump_refill();
      test_rdy_stall();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
